stack_op_sequencer: RTL and testbench

- Multicycle controller that executes one stack-machine operation at a time on an external LIFO: a 64-entry stack with a registered data output.
- Takes an opcode plus immediate through a valid/ready handshake and sequences the stack's push/pop/tos strobes.
- Computes ALU results for arithmetic ops, tracks stack depth, and reports overflow/underflow.
- Sits between the instruction decoder and the stack in the multicycle core.

---
 rtl/stack_op_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - multicycle stack-machine operation sequencer
//
// Purpose:
//   Accepts one stack operation at a time through a valid/ready handshake.
//   It drives the push/pop/tos strobes of an external LIFO that has a
//   registered data output. It computes ALU results and tracks the entry
//   count, and it reports overflow/underflow without executing the failing op.
//
// Optional feature:
//   `define STACK_SEQ_FLAGS_EN adds the flag_z / flag_c outputs.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset, shared with the stack
//   op_valid   in   operation request
//   op_ready   out  high only in IDLE; accept on op_valid && op_ready
//   op_code    in   000 PUSH 001 POP 010 TOS 011 ADD 100 SUB 101 AND 110 OR 111 NOT
//   op_imm     in   PUSH immediate, sampled at accept
//   done       out  one-cycle completion pulse
//   err        out  valid with done: overflow/underflow, op not executed
//   result     out  op result, valid with done, held until the next done
//   depth      out  current stack entry count
//   stk_push   out  stack push strobe
//   stk_pop    out  stack pop strobe
//   stk_tos    out  stack read-top strobe
//   stk_din    out  stack write data
//   stk_dout   in   stack read data, valid the cycle after pop/tos
//   flag_z     out  (STACK_SEQ_FLAGS_EN) result == 0
//   flag_c     out  (STACK_SEQ_FLAGS_EN) ADD carry / SUB borrow

module stack_op_sequencer #(
   parameter int WORD     = 8,
   parameter int LENGTH   = 64,
   parameter int POINTERL = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [2:0]          op_code,
   input  logic [WORD-1:0]     op_imm,
   output logic                done,
   output logic                err,
   output logic [WORD-1:0]     result,
   output logic [POINTERL:0]   depth,
   output logic                stk_push,
   output logic                stk_pop,
   output logic                stk_tos,
   output logic [WORD-1:0]     stk_din,
   input  logic [WORD-1:0]     stk_dout
`ifdef STACK_SEQ_FLAGS_EN
   ,
   output logic                flag_z,
   output logic                flag_c
`endif
);

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_TOS  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;
   localparam logic [2:0] OP_OR   = 3'b110;
   localparam logic [2:0] OP_NOT  = 3'b111;

   // One slot of the array is never usable, so a full stack holds LENGTH-1.
   localparam logic [POINTERL:0] DEPTH_FULL = (POINTERL+1)'(LENGTH - 1);
   localparam logic [POINTERL:0] DEPTH_ONE  = (POINTERL+1)'(1);
   localparam logic [POINTERL:0] DEPTH_TWO  = (POINTERL+1)'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POPA,
      S_POPB,
      S_WAIT,
      S_EXEC,
      S_PUSH,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_d;

   logic [2:0]          r_op;
   logic                r_err;
   logic [WORD-1:0]     r_acc;
   logic [WORD-1:0]     r_b;
   logic [WORD-1:0]     r_result;
   logic [POINTERL:0]   r_depth;

   logic                w_accept;
   logic                w_chk_err;
   logic                w_is_binary;
   logic                w_enter_done;
   logic [WORD:0]       w_alu;
   logic [WORD-1:0]     w_acc_d;

`ifdef STACK_SEQ_FLAGS_EN
   logic                r_carry;
   logic                w_carry_d;
   logic                r_flag_z;
   logic                r_flag_c;
`endif

   // ------------------------------------------------------------------
   // Accept-time legality check
   // ------------------------------------------------------------------
   always_comb begin
      w_chk_err = 1'b0;
      case (op_code)
         OP_PUSH:                w_chk_err = (r_depth == DEPTH_FULL);
         OP_POP, OP_TOS, OP_NOT: w_chk_err = (r_depth == '0);
         default:                w_chk_err = (r_depth < DEPTH_TWO);
      endcase
   end

   assign w_accept    = op_valid && (r_state == S_IDLE);
   assign w_is_binary = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                        (r_op == OP_AND) || (r_op == OP_OR);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and Moore outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_d = r_state;
      op_ready  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_tos   = 1'b0;
      stk_din   = '0;

      case (r_state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               if (w_chk_err) begin
                  w_state_d = S_DONE;
               end else if (op_code == OP_PUSH) begin
                  w_state_d = S_PUSH;
               end else begin
                  w_state_d = S_POPA;
               end
            end
         end
         S_POPA: begin
            // TOS reuses the first pop slot but only reads the top.
            stk_tos   = (r_op == OP_TOS);
            stk_pop   = (r_op != OP_TOS);
            w_state_d = w_is_binary ? S_POPB : S_WAIT;
         end
         S_POPB: begin
            stk_pop   = 1'b1;
            w_state_d = S_EXEC;
         end
         S_WAIT: begin
            w_state_d = (r_op == OP_NOT) ? S_PUSH : S_DONE;
         end
         S_EXEC: begin
            w_state_d = S_PUSH;
         end
         S_PUSH: begin
            stk_push  = 1'b1;
            stk_din   = r_acc;
            w_state_d = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            err       = r_err;
            w_state_d = S_IDLE;
         end
         default: begin
            w_state_d = S_IDLE;
         end
      endcase
   end

   assign w_enter_done = (w_state_d == S_DONE) && (r_state != S_DONE);

   // ------------------------------------------------------------------
   // ALU: a arrives on stk_dout during EXEC, b was captured in POPB.
   // Bit WORD is the carry for ADD and the borrow (a<b) for SUB.
   // ------------------------------------------------------------------
   always_comb begin
      w_alu = '0;
      case (r_op)
         OP_ADD:  w_alu = {1'b0, stk_dout} + {1'b0, r_b};
         OP_SUB:  w_alu = {1'b0, stk_dout} - {1'b0, r_b};
         OP_AND:  w_alu = {1'b0, stk_dout & r_b};
         OP_OR:   w_alu = {1'b0, stk_dout | r_b};
         default: w_alu = '0;
      endcase
   end

   // Next value of the working accumulator. The result register loads this
   // value on the edge entering DONE, because POP/TOS capture stk_dout on
   // that same edge.
   always_comb begin
      w_acc_d = r_acc;
`ifdef STACK_SEQ_FLAGS_EN
      w_carry_d = r_carry;
`endif
      case (r_state)
         S_IDLE: begin
            if (op_valid) begin
               w_acc_d = (!w_chk_err && (op_code == OP_PUSH)) ? op_imm : '0;
`ifdef STACK_SEQ_FLAGS_EN
               w_carry_d = 1'b0;
`endif
            end
         end
         S_WAIT: begin
            w_acc_d = (r_op == OP_NOT) ? ~stk_dout : stk_dout;
         end
         S_EXEC: begin
            w_acc_d = w_alu[WORD-1:0];
`ifdef STACK_SEQ_FLAGS_EN
            w_carry_d = w_alu[WORD];
`endif
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= OP_PUSH;
         r_err    <= 1'b0;
         r_acc    <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_depth  <= '0;
      end else begin
         r_acc <= w_acc_d;

         if (w_accept) begin
            r_op  <= op_code;
            r_err <= w_chk_err;
         end

         if (r_state == S_POPB) begin
            r_b <= stk_dout;
         end

         if (w_enter_done) begin
            r_result <= w_acc_d;
         end

         if (((r_state == S_POPA) && (r_op != OP_TOS)) || (r_state == S_POPB)) begin
            r_depth <= r_depth - DEPTH_ONE;
         end else if (r_state == S_PUSH) begin
            r_depth <= r_depth + DEPTH_ONE;
         end
      end
   end

   assign result = r_result;
   assign depth  = r_depth;

`ifdef STACK_SEQ_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_carry  <= 1'b0;
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
      end else begin
         r_carry <= w_carry_d;
         if (w_enter_done) begin
            r_flag_z <= (w_acc_d == '0);
            r_flag_c <= w_carry_d;
         end
      end
   end

   assign flag_z = r_flag_z;
   assign flag_c = r_flag_c;
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - directed self-checking bench for stack_op_sequencer
module tb_stack_op_sequencer;

   logic       clk;
   logic       rst;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_code;
   logic [7:0] op_imm;
   logic       done;
   logic       err;
   logic [7:0] result;
   logic [6:0] depth;
   logic       stk_push;
   logic       stk_pop;
   logic       stk_tos;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;
`ifdef STACK_SEQ_FLAGS_EN
   logic       flag_z;
   logic       flag_c;
`endif

   localparam logic [2:0] PUSH = 3'b000;
   localparam logic [2:0] POP  = 3'b001;
   localparam logic [2:0] TOS  = 3'b010;
   localparam logic [2:0] ADD  = 3'b011;
   localparam logic [2:0] SUB  = 3'b100;
   localparam logic [2:0] AND_ = 3'b101;
   localparam logic [2:0] OR_  = 3'b110;
   localparam logic [2:0] NOT_ = 3'b111;

   stack_op_sequencer #(.WORD(8), .LENGTH(64), .POINTERL(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_imm   (op_imm),
      .done     (done),
      .err      (err),
      .result   (result),
      .depth    (depth),
      .stk_push (stk_push),
      .stk_pop  (stk_pop),
      .stk_tos  (stk_tos),
      .stk_din  (stk_din),
      .stk_dout (stk_dout)
`ifdef STACK_SEQ_FLAGS_EN
      ,
      .flag_z   (flag_z),
      .flag_c   (flag_c)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External LIFO: 64 entries with a registered read port.
   logic [7:0] mem [0:63];
   logic [6:0] sp;
   logic [5:0] top_idx;
   assign top_idx = sp[5:0] - 6'd1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp       <= '0;
         stk_dout <= '0;
      end else if (stk_push) begin
         mem[sp[5:0]] <= stk_din;
         sp           <= sp + 7'd1;
      end else if (stk_pop) begin
         stk_dout <= mem[top_idx];
         sp       <= sp - 7'd1;
      end else if (stk_tos) begin
         stk_dout <= mem[top_idx];
      end
   end

   int n_chk;
   int n_pass;
   int lat;
   logic o_err;
   logic [7:0] o_res;
   logic any_strobe;
   logic multi_strobe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Issues one op from IDLE, returns latency (cycles after accept to done)
   // and leaves the bench in the following IDLE cycle.
   task automatic run_op(input logic [2:0] code, input logic [7:0] imm);
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = code;
      op_imm   = imm;
      @(posedge clk);
      #1;
      op_valid     = 1'b0;
      lat          = 0;
      any_strobe   = 1'b0;
      multi_strobe = 1'b0;
      o_err        = 1'b0;
      o_res        = '0;
      for (int k = 1; k <= 20; k++) begin
         if (stk_push | stk_pop | stk_tos) any_strobe = 1'b1;
         if ((32'(stk_push) + 32'(stk_pop) + 32'(stk_tos)) > 1) multi_strobe = 1'b1;
         if (done) begin
            lat   = k;
            o_err = err;
            o_res = result;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (lat == 0) chk("done_timeout", 32'(lat), 32'd1);
      chk("one_strobe", 32'(multi_strobe), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      op_valid = 1'b0;
      op_code  = '0;
      op_imm   = '0;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_ready",  32'(op_ready), 32'd1);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_err",    32'(err), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_depth",  32'(depth), 32'd0);
      chk("rst_strobe", 32'({stk_push, stk_pop, stk_tos}), 32'd0);
      chk("rst_din",    32'(stk_din), 32'd0);

      // PUSH 5, PUSH 3, ADD, POP
      run_op(PUSH, 8'h05);
      chk("push5_lat", 32'(lat), 32'd2);
      chk("push5_res", 32'(o_res), 32'h05);
      chk("push5_depth", 32'(depth), 32'd1);
      run_op(PUSH, 8'h03);
      run_op(ADD, 8'h00);
      chk("add_lat", 32'(lat), 32'd5);
      chk("add_err", 32'(o_err), 32'd0);
      chk("add_res", 32'(o_res), 32'h08);
      chk("add_depth", 32'(depth), 32'd1);
      chk("add_result_held", 32'(result), 32'h08);
      run_op(POP, 8'h00);
      chk("pop_lat", 32'(lat), 32'd3);
      chk("pop_res", 32'(o_res), 32'h08);
      chk("pop_depth", 32'(depth), 32'd0);

      // SUB with borrow: 3 - 5
      run_op(PUSH, 8'h03);
      run_op(PUSH, 8'h05);
      run_op(SUB, 8'h00);
      chk("sub_res", 32'(o_res), 32'hFE);
      chk("sub_depth", 32'(depth), 32'd1);
`ifdef STACK_SEQ_FLAGS_EN
      chk("sub_flag_c", 32'(flag_c), 32'd1);
      chk("sub_flag_z", 32'(flag_z), 32'd0);
`endif
      run_op(POP, 8'h00);
      chk("pop_fe", 32'(o_res), 32'hFE);

      // Underflow on empty stack
      run_op(ADD, 8'h00);
      chk("uf_lat", 32'(lat), 32'd1);
      chk("uf_err", 32'(o_err), 32'd1);
      chk("uf_res", 32'(o_res), 32'd0);
      chk("uf_strobe", 32'(any_strobe), 32'd0);
      chk("uf_depth", 32'(depth), 32'd0);
`ifdef STACK_SEQ_FLAGS_EN
      chk("uf_flag_c", 32'(flag_c), 32'd0);
      chk("uf_flag_z", 32'(flag_z), 32'd1);
`endif
      run_op(POP, 8'h00);
      chk("pop_uf_err", 32'(o_err), 32'd1);

      // Fill to capacity, then overflow, then TOS
      for (int i = 1; i <= 63; i++) run_op(PUSH, 8'(i));
      chk("full_depth", 32'(depth), 32'd63);
      run_op(PUSH, 8'h99);
      chk("of_lat", 32'(lat), 32'd1);
      chk("of_err", 32'(o_err), 32'd1);
      chk("of_res", 32'(o_res), 32'd0);
      chk("of_strobe", 32'(any_strobe), 32'd0);
      chk("of_depth", 32'(depth), 32'd63);
      run_op(TOS, 8'h00);
      chk("tos_lat", 32'(lat), 32'd3);
      chk("tos_err", 32'(o_err), 32'd0);
      chk("tos_res", 32'(o_res), 32'h3F);
      chk("tos_depth", 32'(depth), 32'd63);
      do_reset();

      // NOT, AND, OR
      run_op(PUSH, 8'h0F);
      run_op(NOT_, 8'h00);
      chk("not_lat", 32'(lat), 32'd4);
      chk("not_res", 32'(o_res), 32'hF0);
      chk("not_depth", 32'(depth), 32'd1);
      run_op(PUSH, 8'h3C);
      run_op(AND_, 8'h00);
      chk("and_res", 32'(o_res), 32'h30);
      chk("and_depth", 32'(depth), 32'd1);
      run_op(POP, 8'h00);
      run_op(PUSH, 8'hF0);
      run_op(PUSH, 8'h3C);
      run_op(OR_, 8'h00);
      chk("or_res", 32'(o_res), 32'hFC);
      chk("or_depth", 32'(depth), 32'd1);
`ifdef STACK_SEQ_FLAGS_EN
      chk("or_flag_c", 32'(flag_c), 32'd0);
`endif
      run_op(POP, 8'h00);

      // Reset during POPB of an ADD
      run_op(PUSH, 8'h11);
      run_op(PUSH, 8'h22);
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = ADD;
      op_imm   = 8'h00;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      chk("mid_popa", 32'(stk_pop), 32'd1);
      @(posedge clk);
      #1;
      chk("mid_popb", 32'(stk_pop), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_ready", 32'(op_ready), 32'd1);
      chk("mid_rst_depth", 32'(depth), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      any_strobe = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (done | stk_push | stk_pop | stk_tos) any_strobe = 1'b1;
      end
      chk("mid_rst_quiet", 32'(any_strobe), 32'd0);
      run_op(PUSH, 8'hAA);
      chk("after_rst_lat", 32'(lat), 32'd2);
      chk("after_rst_err", 32'(o_err), 32'd0);
      chk("after_rst_res", 32'(o_res), 32'hAA);
      chk("after_rst_depth", 32'(depth), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
